// File: rtl/mem_arb_pkg.sv
// Shared encodings and default sizing for the fetch/data memory-port arbiter.
package mem_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_ISSUE = 2'd1;
  localparam arb_state_t ST_WAIT  = 2'd2;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  localparam int DEF_AWIDTH       = 32;
  localparam int DEF_DWIDTH       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/starve_ctr.sv
// Saturating streak counter: counts data grants that overtook a waiting fetch.
module starve_ctr #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_r;

  // clear wins over increment; saturate at LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != LIM)) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_limit = (cnt_r == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data has priority; a streak counter forces fetch through after STARVE_LIMIT data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH       = DEF_AWIDTH,
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [AWIDTH-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DWIDTH-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DWIDTH/8-1:0] d_wmask,
  input  logic [AWIDTH-1:0]   d_addr,
  input  logic [DWIDTH-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DWIDTH-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [DWIDTH/8-1:0] m_wmask,
  output logic [AWIDTH-1:0]   m_addr,
  output logic [DWIDTH-1:0]   m_wdata,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DWIDTH-1:0]   m_rdata,
  output logic                busy,
  output logic                proto_err
);

  localparam int MW = DWIDTH / 8;

  arb_state_t          state_r;
  arb_state_t          state_nxt_s;
  logic                owner_r;
  logic                drop_r;
  logic                proto_err_r;
  logic                we_r;
  logic [MW-1:0]       wmask_r;
  logic [AWIDTH-1:0]   addr_r;
  logic [DWIDTH-1:0]   wdata_r;

  logic resp_s;
  logic arb_s;
  logic accept_s;
  logic at_limit_s;
  logic fetch_force_s;
  logic pick_i_s;
  logic pick_d_s;

  assign resp_s        = (state_r == ST_WAIT) && m_rvalid;
  assign arb_s         = (state_r == ST_IDLE) || resp_s;
  assign accept_s      = (state_r == ST_ISSUE) && m_ready;
  assign fetch_force_s = i_req && at_limit_s;
  assign pick_d_s      = arb_s && d_req && !fetch_force_s;
  assign pick_i_s      = arb_s && i_req && (fetch_force_s || !d_req);

  starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (d_gnt && i_req),
    .clr      (i_gnt || !i_req),
    .at_limit (at_limit_s)
  );

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_i_s || pick_d_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (m_ready) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (!m_rvalid) begin
          state_nxt_s = ST_WAIT;
        end else if (pick_i_s || pick_d_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // state and the winner's command, captured at arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_D;
      we_r    <= 1'b0;
      wmask_r <= {MW{1'b0}};
      addr_r  <= {AWIDTH{1'b0}};
      wdata_r <= {DWIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (pick_d_s) begin
        owner_r <= OWN_D;
        we_r    <= d_we;
        wmask_r <= d_wmask;
        addr_r  <= d_addr;
        wdata_r <= d_wdata;
      end else if (pick_i_s) begin
        owner_r <= OWN_I;
        we_r    <= 1'b0;
        wmask_r <= {MW{1'b0}};
        addr_r  <= i_addr;
        wdata_r <= {DWIDTH{1'b0}};
      end
    end
  end

  // a redirected fetch still completes to memory; only its response is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_r <= 1'b0;
    end else if (resp_s) begin
      drop_r <= 1'b0;
    end else if (i_flush && (owner_r == OWN_I) && (state_r != ST_IDLE)) begin
      drop_r <= 1'b1;
    end else begin
      drop_r <= drop_r;
    end
  end

  // sticky flag for a response that arrived with nothing outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_r <= 1'b0;
    end else if (m_rvalid && (state_r != ST_WAIT)) begin
      proto_err_r <= 1'b1;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

  assign m_req     = (state_r == ST_ISSUE);
  assign m_we      = we_r;
  assign m_wmask   = wmask_r;
  assign m_addr    = addr_r;
  assign m_wdata   = wdata_r;
  assign busy      = (state_r != ST_IDLE);
  assign proto_err = proto_err_r;

  assign i_gnt    = accept_s && (owner_r == OWN_I);
  assign d_gnt    = accept_s && (owner_r == OWN_D);
  assign i_rvalid = resp_s && (owner_r == OWN_I) && !drop_r && !i_flush;
  assign d_rvalid = resp_s && (owner_r == OWN_D);
  // store responses are acknowledgements only
  assign i_rdata  = i_rvalid ? m_rdata : {DWIDTH{1'b0}};
  assign d_rdata  = (d_rvalid && !we_r) ? m_rdata : {DWIDTH{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a single-outstanding memory model.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_i;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wmask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_wmask;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        busy;
  logic        proto_err;

  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   spur_cyc = -1;
  int   mem_lat = 2;
  exp_t exp_q[$];

  mem_port_arbiter #(
    .AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_wmask(m_wmask), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // memory model: one outstanding request, response mem_lat cycles after acceptance
  initial begin : mem_model
    logic        acc;
    logic [31:0] acc_addr;
    logic        pend_v;
    int          pend_cnt;
    logic [31:0] pend_addr;
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    pend_v   = 1'b0;
    pend_cnt = 0;
    pend_addr = 32'h0;
    forever begin
      @(negedge clk);
      acc      = rst_n && m_req && m_ready;
      acc_addr = m_addr;
      @(posedge clk);
      #1;
      m_rvalid = 1'b0;
      m_rdata  = 32'h0;
      if (!rst_n) begin
        pend_v = 1'b0;
        acc    = 1'b0;
      end
      if (cyc == spur_cyc) begin
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEAD_BEEF;
      end
      if (acc) begin
        pend_v    = 1'b1;
        pend_cnt  = mem_lat;
        pend_addr = acc_addr;
      end
      if (pend_v) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = rd(pend_addr);
          pend_v   = 1'b0;
        end
      end
    end
  end

  // response scoreboard
  initial begin : monitor
    exp_t e;
    logic        obs_i;
    logic [31:0] obs_d;
    forever begin
      @(negedge clk);
      if (rst_n && (i_rvalid || d_rvalid)) begin
        checks++;
        obs_i = i_rvalid;
        obs_d = i_rvalid ? i_rdata : d_rdata;
        if (i_rvalid && d_rvalid) begin
          fails++;
          $display("FAIL resp_both: i_rvalid and d_rvalid together at cycle %0d", cyc);
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected: got is_i=%0b data=%h, required no response", obs_i, obs_d);
        end else begin
          e = exp_q.pop_front();
          if (obs_i !== e.is_i || obs_d !== e.data) begin
            fails++;
            $display("FAIL resp_order: got is_i=%0b data=%h, required is_i=%0b data=%h",
                     obs_i, obs_d, e.is_i, e.data);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic is_i, input logic [31:0] data);
    exp_t e;
    e.is_i = is_i;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input logic is_i);
    logic got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (is_i ? i_gnt : d_gnt) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL gnt_timeout: got no grant, required %s grant", is_i ? "fetch" : "data");
    end
  endtask

  task automatic drain();
    logic done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL drain: got %0d responses pending busy=%0b, required 0 and idle", exp_q.size(), busy);
    end
  endtask

  task automatic drive_i(input logic [31:0] a);
    i_req  = 1'b1;
    i_addr = a;
    wait_gnt(1'b1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic drive_d(input int n, input logic [31:0] base, input logic we);
    for (int k = 0; k < n; k++) begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = base + 32'(4 * k);
      d_wdata = ~d_addr;
      d_wmask = we ? 4'hF : 4'h0;
      wait_gnt(1'b0);
      @(posedge clk); #1;
    end
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_wmask,
         m_addr, m_wdata, busy, proto_err} !== 140'h0) begin
      fails++;
      $display("FAIL reset_outputs: got nonzero outputs busy=%0b m_req=%0b, required all 0", busy, m_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%0b m_req=%0b, required 0 0", busy, m_req);
    end
  endtask

  task automatic test_idle_fetch();
    mem_lat = 2;
    @(posedge clk); #1;
    push_exp(1'b1, rd(32'h0000_1000));
    i_req  = 1'b1;
    i_addr = 32'h0000_1000;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      case (c)
        0: if (m_req !== 1'b0 || i_gnt !== 1'b0) begin
             fails++; $display("FAIL fetch_c0: got m_req=%0b i_gnt=%0b, required 0 0", m_req, i_gnt);
           end
        1: if (m_req !== 1'b1 || i_gnt !== 1'b1 || m_addr !== 32'h0000_1000 || m_we !== 1'b0) begin
             fails++; $display("FAIL fetch_c1: got m_req=%0b i_gnt=%0b m_addr=%h, required 1 1 00001000", m_req, i_gnt, m_addr);
           end
        2: if (i_rvalid !== 1'b0 || busy !== 1'b1) begin
             fails++; $display("FAIL fetch_c2: got i_rvalid=%0b busy=%0b, required 0 1", i_rvalid, busy);
           end
        3: if (i_rvalid !== 1'b1 || i_rdata !== rd(32'h0000_1000)) begin
             fails++; $display("FAIL fetch_c3: got i_rvalid=%0b i_rdata=%h, required 1 %h", i_rvalid, i_rdata, rd(32'h0000_1000));
           end
        default: if (busy !== 1'b0) begin
             fails++; $display("FAIL fetch_c4: got busy=%0b, required 0", busy);
           end
      endcase
      @(posedge clk); #1;
      if (c >= 1) i_req = 1'b0;
    end
    drain();
  endtask

  task automatic test_simultaneous();
    mem_lat = 2;
    @(posedge clk); #1;
    push_exp(1'b0, rd(32'h0000_2000));
    push_exp(1'b1, rd(32'h0000_3000));
    fork
      drive_d(1, 32'h0000_2000, 1'b0);
      drive_i(32'h0000_3000);
      begin
        logic seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (d_rvalid) begin
            seen = 1'b1;
            break;
          end
        end
        @(negedge clk);
        checks++;
        if (!seen || m_req !== 1'b1 || m_addr !== 32'h0000_3000 || m_we !== 1'b0) begin
          fails++;
          $display("FAIL back_to_back: got seen=%0b m_req=%0b m_addr=%h, required 1 1 00003000", seen, m_req, m_addr);
        end
      end
    join
    drain();
  endtask

  task automatic test_starvation();
    mem_lat = 1;
    for (int k = 0; k < 4; k++) push_exp(1'b0, rd(32'h0000_4000 + 32'(4 * k)));
    push_exp(1'b1, rd(32'h0000_5000));
    push_exp(1'b0, rd(32'h0000_4010));
    push_exp(1'b0, rd(32'h0000_4014));
    @(posedge clk); #1;
    fork
      drive_d(6, 32'h0000_4000, 1'b0);
      drive_i(32'h0000_5000);
    join
    drain();
  endtask

  task automatic test_flush();
    mem_lat = 3;
    for (int off = 2; off <= 3; off++) begin
      @(posedge clk); #1;
      i_req  = 1'b1;
      i_addr = 32'h0000_6000;
      wait_gnt(1'b1);
      @(posedge clk); #1;
      i_req = 1'b0;
      repeat (off - 1) begin
        @(posedge clk); #1;
      end
      for (int c = off; c <= 4; c++) begin
        i_flush = (c == off);
        @(negedge clk);
        if (c == 3) begin
          checks++;
          if (i_rvalid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_resp: off=%0d got i_rvalid=%0b busy=%0b, required 0 1", off, i_rvalid, busy);
          end
        end
        if (c == 4) begin
          checks++;
          if (busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: off=%0d got busy=%0b, required 0", off, busy);
          end
        end
        @(posedge clk); #1;
      end
      i_flush = 1'b0;
    end
    push_exp(1'b1, rd(32'h0000_7000));
    drive_i(32'h0000_7000);
    drain();
  endtask

  task automatic test_backpressure();
    logic [70:0] want;
    want = {1'b1, 1'b1, 4'b0110, 32'h0000_8000, 32'h1234_5678, 1'b0};
    mem_lat = 2;
    @(posedge clk); #1;
    push_exp(1'b0, 32'h0);
    m_ready = 1'b0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_8000;
    d_wdata = 32'h1234_5678;
    d_wmask = 4'b0110;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({m_req, m_we, m_wmask, m_addr, m_wdata, d_gnt} !== want) begin
        fails++;
        $display("FAIL bp_stable: cycle %0d got %h, required %h", k, {m_req, m_we, m_wmask, m_addr, m_wdata, d_gnt}, want);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || m_req !== 1'b1) begin
      fails++;
      $display("FAIL bp_gnt: got d_gnt=%0b m_req=%0b, required 1 1", d_gnt, m_req);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b0 || m_req !== 1'b0) begin
      fails++;
      $display("FAIL bp_single_pulse: got d_gnt=%0b m_req=%0b, required 0 0", d_gnt, m_req);
    end
    drain();
  endtask

  task automatic test_proto_reset();
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b0) begin
      fails++;
      $display("FAIL proto_pre: got %0b, required 0", proto_err);
    end
    spur_cyc = cyc + 1;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL proto_no_resp: got i_rvalid=%0b d_rvalid=%0b, required 0 0", i_rvalid, d_rvalid);
    end
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b1) begin
      fails++;
      $display("FAIL proto_set: got %0b, required 1", proto_err);
    end
    mem_lat = 5;
    @(posedge clk); #1;
    i_req  = 1'b1;
    i_addr = 32'h0000_9000;
    wait_gnt(1'b1);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || proto_err !== 1'b1) begin
      fails++;
      $display("FAIL wait_sticky: got busy=%0b proto_err=%0b, required 1 1", busy, proto_err);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we, m_wmask,
         m_addr, m_wdata, busy, proto_err} !== 140'h0) begin
      fails++;
      $display("FAIL async_reset: got busy=%0b m_addr=%h proto_err=%0b, required all 0", busy, m_addr, proto_err);
    end
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || proto_err !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: got busy=%0b proto_err=%0b, required 0 0", busy, proto_err);
    end
    mem_lat = 2;
    push_exp(1'b0, rd(32'h0000_A000));
    @(posedge clk); #1;
    drive_d(1, 32'h0000_A000, 1'b0);
    drain();
  endtask

  initial begin
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    i_flush = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_wmask = 4'h0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    m_ready = 1'b1;
    test_reset();
    test_idle_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_backpressure();
    test_proto_reset();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single backing-memory port between the instruction-fetch requester and the data (load/store) requester. It sits between the fetch stage, the memory/writeback stage and the memory or cache controller. Data accesses have priority, and a starvation counter bounds how long fetch can wait. A fetch flush input drops in-flight fetch responses after a branch mispredict or jump redirect.

## Interface
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width; the write mask is `DWIDTH/8` bits
- `STARVE_LIMIT`, 4, consecutive data grants while fetch waits before fetch is forced to win

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `i_req`  in  1  fetch request; held with `i_addr` stable until `i_gnt`
- `i_addr`  in  AWIDTH  fetch address
- `i_flush`  in  1  drop any fetch response not yet delivered
- `i_gnt`  out  1  one-cycle pulse when the fetch request is accepted by memory
- `i_rvalid`  out  1  fetch response valid, one cycle
- `i_rdata`  out  DWIDTH  fetch data
- `d_req`  in  1  data request; held until `d_gnt`
- `d_we`  in  1  1 = store
- `d_wmask`  in  DWIDTH/8  byte enables
- `d_addr`  in  AWIDTH  data address
- `d_wdata`  in  DWIDTH  store data
- `d_gnt`  out  1  data accept pulse
- `d_rvalid`  out  1  data response valid; loads carry data, stores are acknowledgement only
- `d_rdata`  out  DWIDTH  load data
- `m_req`  out  1  memory request valid
- `m_we`  out  1  memory write enable
- `m_wmask`  out  DWIDTH/8  memory byte enables
- `m_addr`  out  AWIDTH  memory address
- `m_wdata`  out  DWIDTH  memory write data
- `m_ready`  in  1  memory accepts when `m_req && m_ready`
- `m_rvalid`  in  1  exactly one response per accepted request, at least 1 cycle after acceptance
- `m_rdata`  in  DWIDTH  memory read data
- `busy`  out  1  state != IDLE
- `proto_err`  out  1  sticky; cleared only by reset

## Operation
- **States:**
  - IDLE: no transaction in progress.
  - ISSUE: `m_req` high, waiting for `m_ready`.
  - WAIT: request accepted, waiting for `m_rvalid`.
- **Arbitration** happens in IDLE, or in WAIT on the cycle `m_rvalid` arrives.
  - Winner is `d_req`, unless `i_req && streak == STARVE_LIMIT`; then fetch wins.
  - Winner's command is latched into the `m_*` registers and an `owner` flop.
  - Next state is ISSUE. With no request, next state is IDLE.
- **ISSUE:**
  - `m_*` outputs are held stable.
  - On `m_ready`, pulse the owner's `*_gnt` in that same cycle and go to WAIT.
- **WAIT:** on `m_rvalid`:
  - Route `m_rdata` combinationally to the owner's `*_rdata` and assert its `*_rvalid` in that same cycle.
  - Re-arbitrate (back-to-back is allowed).
- **Starvation counter `streak`:**
  - Increments on each data grant while `i_req` is high; saturates at `STARVE_LIMIT`.
  - Clears on a fetch grant, or in any cycle `i_req` is low.
- **Flush:**
  - `i_flush` while the owner is fetch in ISSUE or WAIT sets `drop`.
  - The request is still completed to memory and `m_req` is never withdrawn.
  - When the response arrives, `i_rvalid` is suppressed. `drop` clears at response.
  - `i_flush` in the same cycle as the fetch `m_rvalid` also suppresses that response.
- **Errors:** `m_rvalid` in IDLE or ISSUE is ignored and sets `proto_err`.
- **Request contract:** the arbiter does not check requester-side hold violations.

## Timing
- **Reset values:** state IDLE; all `*_gnt`, `*_rvalid`, `m_req`, `m_we`, `busy` and `proto_err` are 0; `m_wmask`, `m_addr`, `m_wdata`, `*_rdata` and `streak` are 0; `owner` = data; `drop` = 0.
- **Request latency:** request sampled in IDLE at cycle N gives `m_req` at N+1. With `m_ready` already high, grant is at N+1.
- **Response latency:** 0 cycles from `m_rvalid` to `*_rvalid`.
- **Simultaneous `i_req` and `d_req` with `streak` < limit:** data wins.
- **Reset mid-transaction:** asynchronous return to IDLE; the outstanding response is lost; memory is expected to be reset too.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding IDLE/ISSUE/WAIT;
  - the owner encoding OWN_D = 0, OWN_I = 1;
  - default parameter constants.
- One sub-module, `starve_ctr`: saturating counter with `inc`, `clr` and `at_limit`.

## Test plan
- **Idle fetch:** `i_req` at cycle 0 with `m_ready=1` and 2-cycle memory latency, address 0x1000 → `m_req` at cycle 1, `i_gnt` at cycle 1, `i_rvalid` with the memory data at cycle 3.
- **Simultaneous requests:** `i_req` and `d_req` both at cycle 0 → data granted first; fetch issues on the cycle the data `m_rvalid` arrives (back-to-back); `i_rvalid` follows.
- **Starvation:** `d_req` held continuously, `i_req` held, `STARVE_LIMIT=4` → exactly 4 data grants, then a fetch grant, then data resumes.
- **Flush:** fetch in WAIT, `i_flush` pulsed one cycle before `m_rvalid` → no `i_rvalid`, `busy` falls; the next fetch is delivered normally.
- **Memory back-pressure:** `m_ready` held low for 5 cycles in ISSUE → `m_*` stable for all cycles, single grant pulse when `m_ready` rises.
- **Protocol error and reset:** spurious `m_rvalid` in IDLE → `proto_err`=1, no `*_rvalid`. Async `rst_n` low during WAIT → all outputs zero immediately, state IDLE.
